// File: rtl/fpu_operand_fetch.sv
// fpu_operand_fetch
// -----------------
// Sits between the FPU outer instruction queue and the execution core.
// Pops one decoded entry at a time. If the entry has a memory operand, the
// operand is read as 16-bit words and assembled little-endian into an
// 80-bit operand. The complete instruction is then offered to the core with
// a valid/ready handshake. Register-only and store-class entries skip the
// fetch and issue with a zero operand.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   q_empty, q_*          head-of-queue entry fields
//   q_dequeue             combinational single-cycle pop of the queue head
//   mem_req, mem_addr     16-bit read request and word byte address
//   mem_ack, mem_rdata    read data valid this cycle and the data
//   exec_valid/ready      handshake with the execution core
//   exec_*                registered copy of the popped entry
//   exec_operand          assembled operand, zero-extended to 80 bits
//   flush                 abort the current entry and return to IDLE
//   busy                  an entry is being fetched or issued

module fpu_operand_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        q_empty,
  input  logic [7:0]  q_opcode,
  input  logic [2:0]  q_stack_index,
  input  logic [19:0] q_ea,
  input  logic [1:0]  q_operand_size,
  input  logic        q_is_integer,
  input  logic        q_is_bcd,
  input  logic        q_has_memory_op,
  input  logic        q_has_pop,
  output logic        q_dequeue,
  output logic        mem_req,
  output logic [19:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        exec_valid,
  input  logic        exec_ready,
  output logic [7:0]  exec_opcode,
  output logic [2:0]  exec_stack_index,
  output logic [19:0] exec_ea,
  output logic [1:0]  exec_operand_size,
  output logic        exec_is_integer,
  output logic        exec_is_bcd,
  output logic        exec_has_memory_op,
  output logic        exec_has_pop,
  output logic [79:0] exec_operand,
  input  logic        flush,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  word_idx;
  logic [2:0]  last_idx;
  logic [79:0] operand;

  logic [7:0]  opcode_r;
  logic [2:0]  stack_index_r;
  logic [19:0] ea_r;
  logic [1:0]  size_r;
  logic        is_integer_r;
  logic        is_bcd_r;
  logic        has_memory_op_r;
  logic        has_pop_r;

  // Index of the final word for each operand size (1, 2, 4 or 5 words).
  always_comb begin
    last_idx = 3'd0;
    case (size_r)
      2'd0: last_idx = 3'd0;
      2'd1: last_idx = 3'd1;
      2'd2: last_idx = 3'd3;
      2'd3: last_idx = 3'd4;
      default: last_idx = 3'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and the handshake/memory outputs, all decoded from the
  // current state. The pop is suppressed during reset so that every output
  // reads zero while reset is held.
  always_comb begin
    state_next = state;
    q_dequeue  = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = 20'd0;
    exec_valid = 1'b0;
    case (state)
      IDLE: begin
        q_dequeue = !q_empty && !flush && !reset;
        if (q_dequeue) begin
          state_next = q_has_memory_op ? FETCH : ISSUE;
        end
      end
      FETCH: begin
        mem_req  = 1'b1;
        // 20-bit add wraps naturally past 0xFFFFF.
        mem_addr = ea_r + {16'd0, word_idx, 1'b0};
        if (mem_ack && (word_idx == last_idx)) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        exec_valid = 1'b1;
        if (exec_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
    end
  end

  // Entry fields are captured on the pop. Operand words are written only in
  // FETCH, so the operand is frozen while the entry waits in ISSUE. A flush
  // outranks an ack arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      opcode_r        <= 8'd0;
      stack_index_r   <= 3'd0;
      ea_r            <= 20'd0;
      size_r          <= 2'd0;
      is_integer_r    <= 1'b0;
      is_bcd_r        <= 1'b0;
      has_memory_op_r <= 1'b0;
      has_pop_r       <= 1'b0;
      operand         <= 80'd0;
      word_idx        <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (q_dequeue) begin
            opcode_r        <= q_opcode;
            stack_index_r   <= q_stack_index;
            ea_r            <= q_ea;
            size_r          <= q_operand_size;
            is_integer_r    <= q_is_integer;
            is_bcd_r        <= q_is_bcd;
            has_memory_op_r <= q_has_memory_op;
            has_pop_r       <= q_has_pop;
            operand         <= 80'd0;
            word_idx        <= 3'd0;
          end
        end
        FETCH: begin
          if (mem_ack && !flush) begin
            for (int i = 0; i < 5; i++) begin
              if (word_idx == 3'(i)) begin
                operand[16*i +: 16] <= mem_rdata;
              end
            end
            word_idx <= word_idx + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign exec_opcode        = opcode_r;
  assign exec_stack_index   = stack_index_r;
  assign exec_ea            = ea_r;
  assign exec_operand_size  = size_r;
  assign exec_is_integer    = is_integer_r;
  assign exec_is_bcd        = is_bcd_r;
  assign exec_has_memory_op = has_memory_op_r;
  assign exec_has_pop       = has_pop_r;
  assign exec_operand       = operand;
  assign busy               = (state != IDLE);

endmodule

// File: tb/tb_fpu_operand_fetch.sv
// tb_fpu_operand_fetch
// --------------------
// Self-checking bench for fpu_operand_fetch. A queue model feeds entries,
// a memory responder answers reads with programmable wait states, directed
// vectors cover the listed corner cases, and a randomized phase compares
// every issued instruction against a reference model of the entry stream.

module tb_fpu_operand_fetch;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [2:0]  stack_index;
    logic [19:0] ea;
    logic [1:0]  size;
    logic        is_integer;
    logic        is_bcd;
    logic        has_memory_op;
    logic        has_pop;
  } entry_t;

  typedef struct {
    entry_t      e;
    logic [79:0] image;
    int          nwords;
    int          exp_lat;
    logic [79:0] exp_operand;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        q_empty;
  logic [7:0]  q_opcode;
  logic [2:0]  q_stack_index;
  logic [19:0] q_ea;
  logic [1:0]  q_operand_size;
  logic        q_is_integer;
  logic        q_is_bcd;
  logic        q_has_memory_op;
  logic        q_has_pop;
  logic        q_dequeue;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        exec_valid;
  logic        exec_ready;
  logic [7:0]  exec_opcode;
  logic [2:0]  exec_stack_index;
  logic [19:0] exec_ea;
  logic [1:0]  exec_operand_size;
  logic        exec_is_integer;
  logic        exec_is_bcd;
  logic        exec_has_memory_op;
  logic        exec_has_pop;
  logic [79:0] exec_operand;
  logic        flush;
  logic        busy;

  logic        resp_ack;
  logic        stray_ack;
  assign mem_ack = resp_ack | stray_ack;

  fpu_operand_fetch dut (
    .clk(clk), .reset(reset), .q_empty(q_empty), .q_opcode(q_opcode),
    .q_stack_index(q_stack_index), .q_ea(q_ea), .q_operand_size(q_operand_size),
    .q_is_integer(q_is_integer), .q_is_bcd(q_is_bcd),
    .q_has_memory_op(q_has_memory_op), .q_has_pop(q_has_pop),
    .q_dequeue(q_dequeue), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .exec_valid(exec_valid),
    .exec_ready(exec_ready), .exec_opcode(exec_opcode),
    .exec_stack_index(exec_stack_index), .exec_ea(exec_ea),
    .exec_operand_size(exec_operand_size), .exec_is_integer(exec_is_integer),
    .exec_is_bcd(exec_is_bcd), .exec_has_memory_op(exec_has_memory_op),
    .exec_has_pop(exec_has_pop), .exec_operand(exec_operand),
    .flush(flush), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  entry_t      tq[$];
  entry_t      inflight[$];
  logic [15:0] mem_map[logic [19:0]];
  logic [19:0] ack_log[$];
  logic [19:0] req_log[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          model_on = 0;
  bit          resp_on = 1;
  bit          rand_waits = 0;
  int          wait_cnt = 0;
  int          cur_wait = 0;
  int          fetch_k = 0;
  int          issued = 0;
  vec_t        vecs[6];

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic entry_t mk(input logic [7:0] op, input logic [2:0] si,
                                input logic [19:0] ea, input logic [1:0] sz,
                                input logic ii, input logic ib, input logic hm,
                                input logic hp);
    entry_t e;
    e = '{opcode: op, stack_index: si, ea: ea, size: sz, is_integer: ii,
          is_bcd: ib, has_memory_op: hm, has_pop: hp};
    return e;
  endfunction

  function automatic vec_t mkvec(input entry_t e, input logic [79:0] image,
                                 input int nwords, input int lat,
                                 input logic [79:0] exp_op);
    vec_t v;
    v.e = e;
    v.image = image;
    v.nwords = nwords;
    v.exp_lat = lat;
    v.exp_operand = exp_op;
    return v;
  endfunction

  // Memory contents: explicit entries where a test needs them, a fixed
  // address-derived pattern everywhere else.
  function automatic logic [15:0] mem_data(input logic [19:0] a);
    if (mem_map.exists(a)) return mem_map[a];
    return a[15:0] ^ {a[19:16], 12'h9C3};
  endfunction

  function automatic int words_for(input logic [1:0] s);
    case (s)
      2'd0: return 1;
      2'd1: return 2;
      2'd2: return 4;
      default: return 5;
    endcase
  endfunction

  // Reference operand: the needed words read from consecutive halfword
  // addresses (20-bit wrap), word k landing at bit 16*k.
  function automatic logic [79:0] model_operand(input entry_t e);
    logic [79:0] op;
    op = '0;
    if (!e.has_memory_op) return op;
    for (int k = 0; k < words_for(e.size); k++) begin
      op = op | (80'(mem_data(e.ea + 20'(2 * k))) << (16 * k));
    end
    return op;
  endfunction

  function automatic entry_t exec_bundle();
    entry_t e;
    e = {exec_opcode, exec_stack_index, exec_ea, exec_operand_size,
         exec_is_integer, exec_is_bcd, exec_has_memory_op, exec_has_pop};
    return e;
  endfunction

  task automatic drive_head();
    if (tq.size() == 0) begin
      q_empty = 1'b1;
      {q_opcode, q_stack_index, q_ea, q_operand_size, q_is_integer, q_is_bcd,
       q_has_memory_op, q_has_pop} = '0;
    end else begin
      q_empty = 1'b0;
      {q_opcode, q_stack_index, q_ea, q_operand_size, q_is_integer, q_is_bcd,
       q_has_memory_op, q_has_pop} = tq[0];
    end
  endtask

  task automatic respond();
    resp_ack = 1'b0;
    if (mem_req) req_log.push_back(mem_addr);
    if (mem_req && resp_on) begin
      if (wait_cnt >= cur_wait) begin
        resp_ack = 1'b1;
        mem_rdata = mem_data(mem_addr);
        wait_cnt = 0;
        if (rand_waits) cur_wait = $urandom_range(0, 2);
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  endtask

  // One clock: observe pre-edge events, cross the edge, then update the
  // queue and memory models and let combinational outputs settle.
  task automatic step();
    logic   pre_deq;
    logic   pre_hs;
    logic   pre_ack;
    entry_t e;
    pre_deq = q_dequeue;
    pre_hs  = exec_valid && exec_ready;
    pre_ack = mem_ack && mem_req;
    if (pre_ack) begin
      ack_log.push_back(mem_addr);
      if (model_on) begin
        if (inflight.size() == 0) fail_now("random.ack_without_entry");
        else check("random.mem_addr", 80'(mem_addr), 80'(inflight[0].ea + 20'(2 * fetch_k)));
        fetch_k++;
      end
    end
    if (pre_hs && model_on) begin
      if (inflight.size() == 0) begin
        fail_now("random.issue_without_entry");
      end else begin
        e = inflight.pop_front();
        check("random.exec_fields", 80'(exec_bundle()), 80'(e));
        check("random.exec_operand", exec_operand, model_operand(e));
        issued++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    stray_ack = 1'b0;
    if (pre_deq) begin
      if (tq.size() == 0) begin
        fail_now("pop_from_empty_queue");
      end else begin
        e = tq.pop_front();
        if (model_on) begin
          inflight.push_back(e);
          fetch_k = 0;
        end
      end
    end
    drive_head();
    respond();
    #1;
  endtask

  task automatic checkOutput(input string name, input entry_t e, input logic [79:0] op);
    check({name, ".valid"}, 80'(exec_valid), 80'(1));
    check({name, ".fields"}, 80'(exec_bundle()), 80'(e));
    check({name, ".operand"}, exec_operand, op);
  endtask

  task automatic checkIdleOutputs(input string name);
    check({name, ".ctrl"}, 80'({q_dequeue, mem_req, mem_addr, exec_valid, busy}), 80'(0));
    check({name, ".exec"}, 80'(exec_bundle()), 80'(0));
    check({name, ".operand"}, exec_operand, 80'(0));
  endtask

  // Wait for exec_valid, returning the number of cycles since the pop.
  task automatic wait_issue(output int lat, input int bound);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!exec_valid && lat < bound);
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    int    lat;
    string nm;
    nm = $sformatf("vec%0d", idx);
    for (int k = 0; k < v.nwords; k++) mem_map[v.e.ea + 20'(2 * k)] = v.image[16*k +: 16];
    exec_ready = 1'b1;
    cur_wait = 0;
    ack_log.delete();
    tq.push_back(v.e);
    drive_head();
    #1;
    check({nm, ".q_dequeue"}, 80'(q_dequeue), 80'(1));
    wait_issue(lat, 20);
    check({nm, ".latency"}, 80'(lat), 80'(v.exp_lat));
    checkOutput(nm, v.e, v.exp_operand);
    check({nm, ".acks"}, 80'(ack_log.size()), 80'(v.nwords));
    for (int k = 0; k < v.nwords && k < ack_log.size(); k++) begin
      check($sformatf("%s.addr%0d", nm, k), 80'(ack_log[k]), 80'(v.e.ea + 20'(2 * k)));
    end
    step();
    check({nm, ".valid_one_cycle"}, 80'(exec_valid), 80'(0));
    check({nm, ".idle_after"}, 80'(busy), 80'(0));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int     lat;
    entry_t e1;
    entry_t e2;
    entry_t en;
    entry_t re;

    reset = 1'b1;
    flush = 1'b0;
    exec_ready = 1'b0;
    stray_ack = 1'b0;
    resp_ack = 1'b0;
    mem_rdata = 16'd0;
    drive_head();
    repeat (3) step();
    checkIdleOutputs("reset");
    reset = 1'b0;
    step();

    $display("[TB] table vectors");
    vecs[0] = mkvec(mk(8'hD8, 3'd3, 20'h12345, 2'd0, 0, 0, 0, 0), 80'h0, 0, 1, 80'h0);
    vecs[1] = mkvec(mk(8'hD9, 3'd5, 20'hABCDE, 2'd2, 0, 0, 0, 1), 80'h0, 0, 1, 80'h0);
    vecs[2] = mkvec(mk(8'hDF, 3'd0, 20'h00200, 2'd0, 1, 0, 1, 0),
                    80'hBEEF, 1, 2, 80'hBEEF);
    vecs[3] = mkvec(mk(8'hD9, 3'd1, 20'h00300, 2'd1, 0, 0, 1, 0),
                    80'h5678_1234, 2, 3, 80'h5678_1234);
    vecs[4] = mkvec(mk(8'hDD, 3'd2, 20'h00400, 2'd2, 0, 0, 1, 1),
                    80'h0004_0003_0002_0001, 4, 5, 80'h0004_0003_0002_0001);
    vecs[5] = mkvec(mk(8'hDB, 3'd4, 20'h01000, 2'd3, 0, 1, 1, 0),
                    80'h5555_4444_3333_2222_1111, 5, 6, 80'h5555_4444_3333_2222_1111);
    for (int i = 0; i < 6; i++) applyStimulus(i, vecs[i]);

    $display("[TB] address wrap with two wait states");
    mem_map[20'hFFFFE] = 16'hAAAA;
    mem_map[20'h00000] = 16'hBBBB;
    cur_wait = 2;
    req_log.delete();
    e1 = mk(8'hD9, 3'd0, 20'hFFFFE, 2'd1, 0, 0, 1, 0);
    tq.push_back(e1);
    drive_head();
    #1;
    check("wrap.q_dequeue", 80'(q_dequeue), 80'(1));
    wait_issue(lat, 30);
    check("wrap.latency", 80'(lat), 80'(7));
    check("wrap.req_cycles", 80'(req_log.size()), 80'(6));
    for (int k = 0; k < 6 && k < req_log.size(); k++) begin
      check($sformatf("wrap.addr%0d", k), 80'(req_log[k]), 80'((k < 3) ? 20'hFFFFE : 20'h00000));
    end
    checkOutput("wrap", e1, 80'h0000_0000_0000_BBBB_AAAA);
    step();
    cur_wait = 0;

    $display("[TB] backpressure");
    e1 = mk(8'hD8, 3'd1, 20'h00111, 2'd0, 0, 0, 0, 0);
    e2 = mk(8'hDC, 3'd6, 20'h00222, 2'd3, 1, 0, 0, 1);
    exec_ready = 1'b0;
    tq.push_back(e1);
    tq.push_back(e2);
    drive_head();
    #1;
    check("bp.first_pop", 80'(q_dequeue), 80'(1));
    step();
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("bp.hold%0d", c), e1, 80'h0);
      check($sformatf("bp.no_pop%0d", c), 80'(q_dequeue), 80'(0));
      step();
    end
    exec_ready = 1'b1;
    checkOutput("bp.handshake", e1, 80'h0);
    step();
    check("bp.second_pop", 80'(q_dequeue), 80'(1));
    check("bp.valid_low", 80'(exec_valid), 80'(0));
    step();
    checkOutput("bp.second", e2, 80'h0);
    step();

    $display("[TB] flush mid-fetch");
    e1 = mk(8'hDD, 3'd2, 20'h02000, 2'd2, 0, 0, 1, 0);
    en = mk(8'hDF, 3'd7, 20'h02100, 2'd0, 1, 0, 1, 1);
    mem_map[20'h02100] = 16'h7777;
    exec_ready = 1'b1;
    resp_on = 1;
    tq.push_back(e1);
    tq.push_back(en);
    drive_head();
    #1;
    check("flush.pop", 80'(q_dequeue), 80'(1));
    step();
    check("flush.addr0", 80'(mem_addr), 80'(20'h02000));
    resp_on = 0;
    step();
    check("flush.addr1", 80'(mem_addr), 80'(20'h02002));
    flush = 1'b1;
    #1;
    step();
    check("flush.req_low", 80'(mem_req), 80'(0));
    check("flush.valid_low", 80'(exec_valid), 80'(0));
    check("flush.idle", 80'(busy), 80'(0));
    check("flush.no_pop_while_flush", 80'(q_dequeue), 80'(0));
    flush = 1'b0;
    stray_ack = 1'b1;
    mem_rdata = 16'hDEAD;
    #1;
    check("flush.next_pop", 80'(q_dequeue), 80'(1));
    resp_on = 1;
    wait_issue(lat, 20);
    check("flush.next_latency", 80'(lat), 80'(2));
    checkOutput("flush.next", en, 80'h7777);
    exec_ready = 1'b0;
    stray_ack = 1'b1;
    mem_rdata = 16'hFFFF;
    #1;
    step();
    checkOutput("flush.issue_ack_ignored", en, 80'h7777);
    exec_ready = 1'b1;
    step();

    $display("[TB] reset during issue");
    mem_map[20'h03000] = 16'h9999;
    re = mk(8'hDE, 3'd7, 20'h03000, 2'd0, 1, 1, 1, 1);
    exec_ready = 1'b0;
    tq.push_back(re);
    drive_head();
    #1;
    wait_issue(lat, 20);
    checkOutput("rst_issue.before", re, 80'h9999);
    reset = 1'b1;
    #1;
    step();
    checkIdleOutputs("rst_issue.after");
    reset = 1'b0;
    #1;
    step();

    $display("[TB] randomized entries");
    model_on = 1;
    rand_waits = 1;
    cur_wait = 0;
    mem_map.delete();
    issued = 0;
    for (int i = 0; i < 40; i++) begin
      re = mk(8'($urandom), 3'($urandom), 20'($urandom), 2'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tq.push_back(re);
    end
    drive_head();
    #1;
    for (int budget = 0; issued < 40 && budget < 4000; budget++) begin
      exec_ready = ($urandom_range(0, 3) != 0);
      check("random.pop_only_idle", 80'(q_dequeue & busy), 80'(0));
      step();
    end
    check("random.all_issued", 80'(issued), 80'(40));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
